// File: rtl/uart_rx.sv
// 8N1 UART receiver: LSB first, idle-high line, fixed CLKS_PER_BIT timing.
// Two-flop synchroniser, start-bit qualification at mid-bit, bit-centre sampling.
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_uart_rx,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Err
);

  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            dv_q, dv_d;
  logic            err_q, err_d;
  logic            active_q, active_d;
  logic            sync1_q, sync2_q;
  logic            rx_s;

  // Synchroniser resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep the two flops as a real two-stage pipeline.
      sync1_q <= i_uart_rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;   // high at mid-bit: glitch, drop silently
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_HIGH: begin
        // Break conditions are absorbed here until the line returns to idle.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    active_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
  end

  assign o_RX_DV     = dv_q;
  assign o_RX_Err    = err_q;
  assign o_RX_Byte   = byte_q;
  assign o_RX_Active = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-accurate serial driver, expected-byte
// queue filled at stimulus time and drained against captured o_RX_DV bytes.
module tb_uart_rx;

  localparam int CPB     = 87;
  localparam int LATENCY = 829;

  logic       clk;
  logic       rst_n;
  logic       rx_line;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_active;
  logic       rx_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_uart_rx  (rx_line),
    .o_RX_DV    (rx_dv),
    .o_RX_Byte  (rx_byte),
    .o_RX_Active(rx_active),
    .o_RX_Err   (rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every strobe; only the tasks compare.
  logic [7:0] got_byte [16];
  int         got_cyc  [16];
  int dv_count     = 0;
  int err_count    = 0;
  int both_count   = 0;
  int active_count = 0;
  always @(negedge clk) begin
    if (rx_dv) begin
      if (dv_count < 16) begin
        got_byte[dv_count] <= rx_byte;
        got_cyc[dv_count]  <= cyc;
      end
      dv_count <= dv_count + 1;
    end
    if (rx_err)           err_count    <= err_count + 1;
    if (rx_dv && rx_err)  both_count   <= both_count + 1;
    if (rx_active)        active_count <= active_count + 1;
  end

  logic [7:0] exp_q [$];
  int rd = 0;
  int last_start_cyc = 0;

  // Drives one frame starting at a negedge; stop_level=0 forces a framing error.
  task automatic send_frame(input logic [7:0] b, input logic stop_level, input bit expect_good);
    @(negedge clk);
    last_start_cyc = cyc + 1;
    if (expect_good) exp_q.push_back(b);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = stop_level;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_dv(input int target, input string name);
    for (int c = 0; c < 3000 && dv_count < target; c++) @(negedge clk);
    tests++;
    if (dv_count < target) begin
      fails++;
      $display("FAIL %s timeout: got %0d strobes, required %0d", name, dv_count, target);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    rx_line = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rx_line = ~rx_line;
      if (i % 10 == 9) begin
        tests++;
        if ({rx_dv, rx_err, rx_active, rx_byte} !== 11'd0) begin
          fails++;
          $display("FAIL reset_outputs: dv=%b err=%b act=%b byte=%h, required all 0",
                   rx_dv, rx_err, rx_active, rx_byte);
        end
      end
    end
    rx_line = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    tests++;
    if (dv_count !== 0 || err_count !== 0 || active_count !== 0) begin
      fails++;
      $display("FAIL reset_quiet: dv=%0d err=%0d active=%0d, required 0 0 0",
               dv_count, err_count, active_count);
    end
  endtask

  task automatic test_single();
    int e0 = err_count;
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_dv(1, "single");
    repeat (20) @(negedge clk);
    tests++;
    if (dv_count !== 1) begin
      fails++;
      $display("FAIL single_count: got %0d strobes, required 1", dv_count);
    end
    while (rd < dv_count && rd < 16) begin
      logic [7:0] e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      tests++;
      if (got_byte[rd] !== e) begin
        fails++;
        $display("FAIL single_byte: got %h, required %h", got_byte[rd], e);
      end
      tests++;
      if (got_cyc[rd] - last_start_cyc !== LATENCY) begin
        fails++;
        $display("FAIL single_latency: got %0d, required %0d", got_cyc[rd] - last_start_cyc, LATENCY);
      end
      rd++;
    end
    tests++;
    if (rx_byte !== 8'hA5 || err_count !== e0 || rx_active !== 1'b0) begin
      fails++;
      $display("FAIL single_hold: byte=%h err=%0d act=%b, required A5 %0d 0", rx_byte, err_count, rx_active, e0);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = dv_count;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_dv(d0 + 3, "b2b");
    repeat (20) @(negedge clk);
    tests++;
    if (dv_count - d0 !== 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d strobes, required 3", dv_count - d0);
    end
    while (rd < dv_count && rd < 16) begin
      logic [7:0] e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      tests++;
      if (got_byte[rd] !== e) begin
        fails++;
        $display("FAIL b2b_byte[%0d]: got %h, required %h", rd, got_byte[rd], e);
      end
      rd++;
    end
  endtask

  task automatic test_glitch();
    int d0 = dv_count;
    int e0 = err_count;
    int a0 = active_count;
    @(negedge clk);
    rx_line = 1'b0;
    repeat (20) @(negedge clk);
    rx_line = 1'b1;
    repeat (200) @(negedge clk);
    tests++;
    if (active_count == a0) begin
      fails++;
      $display("FAIL glitch_active_pulse: active cycles %0d, required > 0", active_count - a0);
    end
    tests++;
    if (rx_active !== 1'b0 || dv_count !== d0 || err_count !== e0) begin
      fails++;
      $display("FAIL glitch_reject: act=%b dv=%0d err=%0d, required 0 0 0",
               rx_active, dv_count - d0, err_count - e0);
    end
  endtask

  task automatic test_framing();
    int d0 = dv_count;
    int e0 = err_count;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (500) @(negedge clk);
    rx_line = 1'b1;
    repeat (300) @(negedge clk);
    tests++;
    if (err_count - e0 !== 1 || dv_count !== d0) begin
      fails++;
      $display("FAIL framing_err: err=%0d dv=%0d, required 1 0", err_count - e0, dv_count - d0);
    end
    tests++;
    if (rx_byte !== 8'h3C || rx_active !== 1'b0) begin
      fails++;
      $display("FAIL framing_hold: byte=%h act=%b, required 3C 0", rx_byte, rx_active);
    end
    send_frame(8'hC3, 1'b1, 1'b1);
    wait_dv(d0 + 1, "framing_recover");
    repeat (20) @(negedge clk);
    while (rd < dv_count && rd < 16) begin
      logic [7:0] e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      tests++;
      if (got_byte[rd] !== e) begin
        fails++;
        $display("FAIL framing_recover_byte: got %h, required %h", got_byte[rd], e);
      end
      rd++;
    end
    tests++;
    if (err_count - e0 !== 1 || both_count !== 0) begin
      fails++;
      $display("FAIL framing_strobes: err=%0d both=%0d, required 1 0", err_count - e0, both_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b = 8'h81;
    int d0 = dv_count;
    int e0 = err_count;
    @(negedge clk);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_line = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({rx_dv, rx_err, rx_active, rx_byte} !== 11'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs: dv=%b err=%b act=%b byte=%h, required all 0",
               rx_dv, rx_err, rx_active, rx_byte);
    end
    repeat (CPB - CPB / 2) @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      rx_line = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = 1'b1;
    repeat (CPB + 20) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    tests++;
    if (dv_count !== d0 || err_count !== e0) begin
      fails++;
      $display("FAIL reset_mid_nostrobe: dv=%0d err=%0d, required 0 0", dv_count - d0, err_count - e0);
    end
    send_frame(8'h42, 1'b1, 1'b1);
    wait_dv(d0 + 1, "reset_mid_next");
    repeat (20) @(negedge clk);
    while (rd < dv_count && rd < 16) begin
      logic [7:0] e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      tests++;
      if (got_byte[rd] !== e) begin
        fails++;
        $display("FAIL reset_mid_next_byte: got %h, required %h", got_byte[rd], e);
      end
      rd++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
    tests++;
    if (exp_q.size() != 0 || dv_count !== 6) begin
      fails++;
      $display("FAIL scoreboard_drain: pending %0d, strobes %0d, required 0 and 6", exp_q.size(), dv_count);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
